// File: rtl/bus_xfer_seq_if.sv
// Command, memory handshake and transfer-gate signals between decode,
// memory and the bus transfer sequencer.
interface bus_xfer_seq_if;
    logic       start;
    logic [1:0] op;
    logic [3:0] src_sel;
    logic [2:0] dst_sel;
    logic       mem_ready;

    logic [7:0] ra_gate;
    logic       mda_gate;
    logic       b0_gate;
    logic       als_gate;
    logic       shs_gate;
    logic       mdm_gate;
    logic [7:0] reg_we;
    logic       mar_load;
    logic       mdr_load;
    logic       mem_rd;
    logic       mem_wr;
    logic       busy;
    logic       done;
    logic       err;

    // Decode/memory side: issues commands and completion strobes.
    modport master (
        output start, op, src_sel, dst_sel, mem_ready,
        input  ra_gate, mda_gate, b0_gate, als_gate, shs_gate, mdm_gate,
               reg_we, mar_load, mdr_load, mem_rd, mem_wr, busy, done, err
    );

    // Sequencer side: drives gate enables and memory requests.
    modport slave (
        input  start, op, src_sel, dst_sel, mem_ready,
        output ra_gate, mda_gate, b0_gate, als_gate, shs_gate, mdm_gate,
               reg_we, mar_load, mdr_load, mem_rd, mem_wr, busy, done, err
    );
endinterface

// File: rtl/bus_xfer_seq.sv
// Micro-step sequencer for the 16-bit register-transfer datapath: one command
// at a time, one A-bus and one S-bus source per cycle, bounded memory wait.
module bus_xfer_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_xfer_seq_if.slave   bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned RA_N  = 8;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_SHIFT = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GATE  = 3'd1,
        DGATE = 3'd2,
        MWAIT = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] src;
        logic [2:0] dst;
    } cmd_t;

    typedef struct packed {
        logic [RA_N-1:0] ra_gate;
        logic            mda_gate;
        logic            b0_gate;
        logic            als_gate;
        logic            shs_gate;
        logic            mdm_gate;
        logic [RA_N-1:0] reg_we;
        logic            mar_load;
        logic            mdr_load;
        logic            mem_rd;
        logic            mem_wr;
        logic            busy;
        logic            done;
        logic            err;
    } out_t;

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    out_t               out_q, out_d;

    // Source 8 is MDA and only feeds ALU/SHIFT; 9..15 never exist.
    function automatic logic src_illegal(input op_t op, input logic [3:0] src);
        logic mem_op;
        mem_op = (op == OP_LOAD) || (op == OP_STORE);
        return src[3] && ((src[2:0] != 3'd0) || mem_op);
    endfunction

    // Moore decode of the gate pattern for a given state and latched command.
    function automatic out_t decode(input state_t s, input cmd_t c, input logic e);
        out_t o;
        o = '0;
        case (s)
            GATE: begin
                if (c.src[3]) begin
                    o.mda_gate = 1'b1;
                end else begin
                    o.ra_gate = RA_N'(1) << c.src[2:0];
                end
                o.b0_gate  = 1'b1;
                o.mar_load = (c.op == OP_LOAD) || (c.op == OP_STORE);
            end
            DGATE: begin
                o.ra_gate  = RA_N'(1) << c.dst;
                o.mdr_load = 1'b1;
            end
            MWAIT: begin
                o.mem_rd = (c.op == OP_LOAD);
                o.mem_wr = (c.op == OP_STORE);
            end
            WB: begin
                o.reg_we   = RA_N'(1) << c.dst;
                o.als_gate = (c.op == OP_ALU);
                o.shs_gate = (c.op == OP_SHIFT);
                o.mdm_gate = (c.op == OP_LOAD);
            end
            DONE: begin
                o.done = 1'b1;
                o.err  = e;
            end
            default: ;
        endcase
        o.busy = (s != IDLE);
        return o;
    endfunction

    // State, command, wait counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // appear registered in the same cycle the state does.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = '0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cmd_d.op  = op_t'(bus.op);
                    cmd_d.src = bus.src_sel;
                    cmd_d.dst = bus.dst_sel;
                    if (src_illegal(op_t'(bus.op), bus.src_sel)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = GATE;
                        err_d   = 1'b0;
                    end
                end
            end
            GATE: begin
                case (cmd_q.op)
                    OP_LOAD:  state_d = MWAIT;
                    OP_STORE: state_d = DGATE;
                    default:  state_d = WB;
                endcase
            end
            DGATE: state_d = MWAIT;
            MWAIT: begin
                if (bus.mem_ready) begin
                    state_d = (cmd_q.op == OP_LOAD) ? WB : DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        out_d = decode(state_d, cmd_d, err_d);
    end

    assign bus.ra_gate  = out_q.ra_gate;
    assign bus.mda_gate = out_q.mda_gate;
    assign bus.b0_gate  = out_q.b0_gate;
    assign bus.als_gate = out_q.als_gate;
    assign bus.shs_gate = out_q.shs_gate;
    assign bus.mdm_gate = out_q.mdm_gate;
    assign bus.reg_we   = out_q.reg_we;
    assign bus.mar_load = out_q.mar_load;
    assign bus.mdr_load = out_q.mdr_load;
    assign bus.mem_rd   = out_q.mem_rd;
    assign bus.mem_wr   = out_q.mem_wr;
    assign bus.busy     = out_q.busy;
    assign bus.done     = out_q.done;
    assign bus.err      = out_q.err;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Scoreboard bench for bus_xfer_seq: stimulus queues the expected per-cycle
// output pattern of each command; a negedge monitor pops it while busy.
module tb_bus_xfer_seq;

    typedef struct packed {
        logic [7:0] ra;
        logic       mda;
        logic       b0;
        logic       als;
        logic       shs;
        logic       mdm;
        logic [7:0] we;
        logic       mar;
        logic       mdr;
        logic       rd;
        logic       wr;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    bus_xfer_seq_if bus();

    bus_xfer_seq #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.ra   = bus.ra_gate;
        o.mda  = bus.mda_gate;
        o.b0   = bus.b0_gate;
        o.als  = bus.als_gate;
        o.shs  = bus.shs_gate;
        o.mdm  = bus.mdm_gate;
        o.we   = bus.reg_we;
        o.mar  = bus.mar_load;
        o.mdr  = bus.mdr_load;
        o.rd   = bus.mem_rd;
        o.wr   = bus.mem_wr;
        o.busy = bus.busy;
        o.done = bus.done;
        o.err  = bus.err;
        return o;
    endfunction

    // Expected-pattern builders; callers pass hand-computed values.
    function automatic obs_t e_gate(input logic [7:0] ra, input logic mda, input logic mar);
        obs_t o = '0;
        o.ra = ra; o.mda = mda; o.b0 = 1'b1; o.mar = mar; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_dgate(input logic [7:0] ra);
        obs_t o = '0;
        o.ra = ra; o.mdr = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_mwait(input logic rd, input logic wr);
        obs_t o = '0;
        o.rd = rd; o.wr = wr; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_wb(input logic [7:0] we, input logic als, input logic shs, input logic mdm);
        obs_t o = '0;
        o.we = we; o.als = als; o.shs = shs; o.mdm = mdm; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_done(input logic err);
        obs_t o = '0;
        o.busy = 1'b1; o.done = 1'b1; o.err = err;
        return o;
    endfunction

    task automatic push(input obs_t v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drives one command; returns one step after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] src, input logic [2:0] dst);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.src_sel = src;
        bus.dst_sel = dst;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy !== 1'b0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, bus.busy, k);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop while busy.
    obs_t  mon_act;
    obs_t  mon_exp;
    string mon_tag;
    always @(negedge clk) begin
        mon_act = sample();

        n_chk++;
        if (($countones(mon_act.ra) + 32'(mon_act.mda)) > 1) begin
            n_fail++;
            $display("FAIL inv_abus: ra=%h mda=%b, required at most one source", mon_act.ra, mon_act.mda);
        end
        n_chk++;
        if ((32'(mon_act.als) + 32'(mon_act.shs) + 32'(mon_act.mdm)) > 1) begin
            n_fail++;
            $display("FAIL inv_sbus: als=%b shs=%b mdm=%b, required at most one", mon_act.als, mon_act.shs, mon_act.mdm);
        end
        n_chk++;
        if ($countones(mon_act.we) > 1 || (mon_act.rd && mon_act.wr) || (mon_act.err && !mon_act.done)) begin
            n_fail++;
            $display("FAIL inv_misc: we=%h rd=%b wr=%b err=%b done=%b", mon_act.we, mon_act.rd, mon_act.wr, mon_act.err, mon_act.done);
        end

        n_chk++;
        if (mon_act.busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_busy: got %h expected idle", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", mon_tag, mon_act, mon_exp);
                end
            end
        end else if (mon_act !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected 0", mon_act);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.src_sel   = 4'd0;
        bus.dst_sel   = 3'd0;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        check("reset_state", sample(), '0);
        #1 rst_n = 1'b1;

        // ALU RA3 -> R5
        push(e_gate(8'h08, 1'b0, 1'b0), "alu_gate");
        push(e_wb(8'h20, 1'b1, 1'b0, 1'b0), "alu_wb");
        push(e_done(1'b0), "alu_done");
        issue(2'b00, 4'd3, 3'd5);
        wait_idle("alu");

        // SHIFT MDA -> R0
        push(e_gate(8'h00, 1'b1, 1'b0), "shift_gate");
        push(e_wb(8'h01, 1'b0, 1'b1, 1'b0), "shift_wb");
        push(e_done(1'b0), "shift_done");
        issue(2'b01, 4'd8, 3'd0);
        wait_idle("shift");

        // LOAD addr RA2 -> R7, mem_ready on the third MWAIT cycle
        push(e_gate(8'h04, 1'b0, 1'b1), "load_gate");
        for (int i = 0; i < 3; i++) push(e_mwait(1'b1, 1'b0), "load_mwait");
        push(e_wb(8'h80, 1'b0, 1'b0, 1'b1), "load_wb");
        push(e_done(1'b0), "load_done");
        issue(2'b10, 4'd2, 3'd7);
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        @(posedge clk); #1 bus.mem_ready = 1'b0;
        wait_idle("load");

        // STORE addr RA6, data R2, mem_ready in the first MWAIT cycle
        push(e_gate(8'h40, 1'b0, 1'b1), "store_gate");
        push(e_dgate(8'h04), "store_dgate");
        push(e_mwait(1'b0, 1'b1), "store_mwait");
        push(e_done(1'b0), "store_done");
        issue(2'b11, 4'd6, 3'd2);
        repeat (2) @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        @(posedge clk); #1 bus.mem_ready = 1'b0;
        wait_idle("store");

        // STORE timeout: 16 MWAIT cycles then done with err
        push(e_gate(8'h02, 1'b0, 1'b1), "sto_to_gate");
        push(e_dgate(8'h10), "sto_to_dgate");
        for (int i = 0; i < 16; i++) push(e_mwait(1'b0, 1'b1), "sto_to_mwait");
        push(e_done(1'b1), "sto_to_done");
        issue(2'b11, 4'd1, 3'd4);
        wait_idle("store_timeout");

        // Illegal sources
        push(e_done(1'b1), "illegal_src12");
        issue(2'b00, 4'd12, 3'd3);
        wait_idle("illegal_src12");
        push(e_done(1'b1), "illegal_load_mda");
        issue(2'b10, 4'd8, 3'd1);
        wait_idle("illegal_load_mda");

        // start held through a busy ALU command is ignored
        push(e_gate(8'h08, 1'b0, 1'b0), "ign_gate");
        push(e_wb(8'h20, 1'b1, 1'b0, 1'b0), "ign_wb");
        push(e_done(1'b0), "ign_done");
        issue(2'b00, 4'd3, 3'd5);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_sel = 4'd0; bus.dst_sel = 3'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("ignore_busy");

        // Back-to-back: start raised in DONE is taken only in the following IDLE
        push(e_gate(8'h10, 1'b0, 1'b0), "b2b1_gate");
        push(e_wb(8'h40, 1'b1, 1'b0, 1'b0), "b2b1_wb");
        push(e_done(1'b0), "b2b1_done");
        issue(2'b00, 4'd4, 3'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        push(e_gate(8'h80, 1'b0, 1'b0), "b2b2_gate");
        push(e_wb(8'h04, 1'b0, 1'b1, 1'b0), "b2b2_wb");
        push(e_done(1'b0), "b2b2_done");
        bus.start = 1'b1; bus.op = 2'b01; bus.src_sel = 4'd7; bus.dst_sel = 3'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("back_to_back");

        // Reset asserted mid-MWAIT of a LOAD: outputs clear, no done pulse
        push(e_gate(8'h01, 1'b0, 1'b1), "rst_gate");
        for (int i = 0; i < 3; i++) push(e_mwait(1'b1, 1'b0), "rst_mwait");
        issue(2'b10, 4'd0, 3'd3);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1 check("reset_immediate", sample(), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_leftover: %0d expected cycles unseen, required 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end

        push(e_gate(8'h20, 1'b0, 1'b0), "post_rst_gate");
        push(e_wb(8'h02, 1'b1, 1'b0, 1'b0), "post_rst_wb");
        push(e_done(1'b0), "post_rst_done");
        issue(2'b00, 4'd5, 3'd1);
        wait_idle("post_reset");

        repeat (3) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d expected cycles unseen, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
